scr1_wdt: RTL



---
 rtl/scr1_wdt_pkg.sv | 47 ++++
 rtl/scr1_wdt_if.sv | 27 ++
 rtl/scr1_wdt_cnt.sv | 33 +++
 rtl/scr1_wdt.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scr1_wdt_pkg.sv
// Watchdog shared definitions: register map, bit offsets, FSM
// encoding and the dmem request/response types.
package scr1_wdt_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;
  localparam int SCR1_WDT_AWIDTH  = 5;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  localparam logic [4:0] SCR1_WDT_ADDR_CONTROL = 5'h00;
  localparam logic [4:0] SCR1_WDT_ADDR_TIMEOUT = 5'h04;
  localparam logic [4:0] SCR1_WDT_ADDR_KICK    = 5'h08;
  localparam logic [4:0] SCR1_WDT_ADDR_STATUS  = 5'h0C;
  localparam logic [4:0] SCR1_WDT_ADDR_WINDOW  = 5'h10;

  localparam int SCR1_WDT_CTRL_EN    = 0;
  localparam int SCR1_WDT_CTRL_LOCK  = 1;
  localparam int SCR1_WDT_CTRL_RSTEN = 2;

  localparam int SCR1_WDT_STAT_IRQ = 0;
  localparam int SCR1_WDT_STAT_EXP = 1;

  typedef enum logic [1:0] {
    SCR1_WDT_IDLE  = 2'd0,
    SCR1_WDT_ARMED = 2'd1,
    SCR1_WDT_WARN  = 2'd2,
    SCR1_WDT_BITE  = 2'd3
  } type_scr1_wdt_fsm_e;

endpackage

// File: rtl/scr1_wdt_if.sv
// dmem slave port bundle of the watchdog.
// master drives requests, slave answers.
interface scr1_wdt_if;
  import scr1_wdt_pkg::*;

  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_width_e        dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
  logic                        dmem_req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width,
    output dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width,
    input  dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/scr1_wdt_cnt.sv
// Timer tick detector and 32-bit watchdog down-counter.
// expire flags the tick that moves the counter from 1 to 0.
module scr1_wdt_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] timer_lo,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expire,
  output logic [31:0] cnt
);

  logic [31:0] tval_q;
  logic        tick;

  assign tick   = timer_lo != tval_q;
  assign expire = run & tick & (cnt == 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tval_q <= '0;
      cnt    <= '0;
    end else begin
      tval_q <= timer_lo;
      if (load)
        cnt <= load_val;
      else if (run && tick && cnt != '0)
        cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/scr1_wdt.sv
// Two-stage watchdog on the dmem bus: IRQ on first expiry, reset on second.
// SCR1_WDT_WINDOW_EN adds the WINDOW register and early-kick checking.
module scr1_wdt
  import scr1_wdt_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_RST = 32'h0001_0000,
  parameter logic [31:0] KICK_KEY    = 32'h5A5A_A5A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] timer_val,
  scr1_wdt_if.slave   dmem,
  output logic        wdt_irq,
  output logic        wdt_rst_req
);

  logic [SCR1_WDT_AWIDTH-1:0] addr;
  logic [31:0] wdata;
  logic        hit, acc_ok, wr_ok, live, run;
  logic        wr_ctrl, wr_tmo, wr_stat, kick;
  logic        key_ok, kick_good, kick_bad;
  logic        ctrl_off, set_irq, cnt_load, expire;
  logic        en, lock, rsten, irq_pend, expired;
  logic [31:0] timeout, load_val, cnt, rd_val;
  type_scr1_wdt_fsm_e state;
`ifdef SCR1_WDT_WINDOW_EN
  logic [31:0] window;
  logic        wr_win;
`endif

  assign addr  = dmem.dmem_addr[SCR1_WDT_AWIDTH-1:0];
  assign wdata = dmem.dmem_wdata;
  assign dmem.dmem_req_ack = 1'b1;

  always_comb begin
    hit    = 1'b0;
    rd_val = '0;
    case (addr)
      SCR1_WDT_ADDR_CONTROL: begin
        hit    = 1'b1;
        rd_val = {29'd0, rsten, lock, en};
      end
      SCR1_WDT_ADDR_TIMEOUT: begin
        hit    = 1'b1;
        rd_val = timeout;
      end
      SCR1_WDT_ADDR_KICK: hit = 1'b1;
      SCR1_WDT_ADDR_STATUS: begin
        hit    = 1'b1;
        rd_val = {28'd0, state, expired, irq_pend};
      end
`ifdef SCR1_WDT_WINDOW_EN
      SCR1_WDT_ADDR_WINDOW: begin
        hit    = 1'b1;
        rd_val = window;
      end
`endif
      default: ;
    endcase
  end

  assign acc_ok = hit
    & (dmem.dmem_width == SCR1_MEM_WIDTH_WORD);
  assign wr_ok  = dmem.dmem_req & acc_ok
    & (dmem.dmem_cmd == SCR1_MEM_CMD_WR);
  assign live   = state != SCR1_WDT_BITE;
  assign run    = (state == SCR1_WDT_ARMED)
    | (state == SCR1_WDT_WARN);

  assign wr_ctrl = wr_ok & live & ~lock
    & (addr == SCR1_WDT_ADDR_CONTROL);
  assign wr_tmo  = wr_ok & live & ~lock
    & (addr == SCR1_WDT_ADDR_TIMEOUT);
  assign wr_stat = wr_ok & live
    & (addr == SCR1_WDT_ADDR_STATUS);
  assign kick    = wr_ok & run
    & (addr == SCR1_WDT_ADDR_KICK);

`ifdef SCR1_WDT_WINDOW_EN
  assign wr_win = wr_ok & live
    & (addr == SCR1_WDT_ADDR_WINDOW);
  assign key_ok = (wdata == KICK_KEY) & (cnt <= window);
`else
  assign key_ok = wdata == KICK_KEY;
`endif

  assign kick_good = kick & key_ok;
  assign kick_bad  = kick & ~key_ok;
  assign ctrl_off  = wr_ctrl & ~wdata[SCR1_WDT_CTRL_EN];
  assign load_val  = (timeout == '0) ? 32'd1 : timeout;

  // Only a real ARMED->WARN step raises the warning
  assign set_irq = expire & (state == SCR1_WDT_ARMED)
    & ~kick_good & ~ctrl_off & ~(kick_bad & rsten);

  assign cnt_load = (wr_ctrl & wdata[SCR1_WDT_CTRL_EN]
      & (state == SCR1_WDT_IDLE))
    | kick_good
    | (expire & ~((state == SCR1_WDT_WARN) & rsten));

  scr1_wdt_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_lo (timer_val[31:0]),
    .run      (run),
    .load     (cnt_load),
    .load_val (load_val),
    .expire   (expire),
    .cnt      (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en       <= 1'b0;
      lock     <= 1'b0;
      rsten    <= 1'b0;
      irq_pend <= 1'b0;
      expired  <= 1'b0;
      timeout  <= TIMEOUT_RST;
      state    <= SCR1_WDT_IDLE;
`ifdef SCR1_WDT_WINDOW_EN
      window   <= '0;
`endif
    end else begin
      if (wr_ctrl) begin
        en    <= wdata[SCR1_WDT_CTRL_EN];
        lock  <= wdata[SCR1_WDT_CTRL_LOCK];
        rsten <= wdata[SCR1_WDT_CTRL_RSTEN];
      end
      if (wr_tmo)
        timeout <= wdata;
`ifdef SCR1_WDT_WINDOW_EN
      if (wr_win)
        window <= wdata;
`endif
      if (kick_bad)
        expired <= 1'b1;
      if (set_irq)
        irq_pend <= 1'b1;
      else if (wr_stat && wdata[SCR1_WDT_STAT_IRQ])
        irq_pend <= 1'b0;

      unique case (state)
        SCR1_WDT_IDLE: begin
          if (wr_ctrl && wdata[SCR1_WDT_CTRL_EN])
            state <= SCR1_WDT_ARMED;
        end
        SCR1_WDT_ARMED, SCR1_WDT_WARN: begin
          if (ctrl_off)
            state <= SCR1_WDT_IDLE;
          else if (kick_good)
            state <= SCR1_WDT_ARMED;
          else if (kick_bad && rsten)
            state <= SCR1_WDT_BITE;
          else if (expire) begin
            if (state == SCR1_WDT_ARMED)
              state <= SCR1_WDT_WARN;
            else if (rsten)
              state <= SCR1_WDT_BITE;
          end
        end
        SCR1_WDT_BITE: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem.dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem.dmem_rdata <= '0;
    end else begin
      dmem.dmem_rdata <= '0;
      if (!dmem.dmem_req)
        dmem.dmem_resp <= SCR1_MEM_RESP_NOTRDY;
      else if (!acc_ok)
        dmem.dmem_resp <= SCR1_MEM_RESP_RDY_ER;
      else begin
        dmem.dmem_resp <= SCR1_MEM_RESP_RDY_OK;
        if (dmem.dmem_cmd == SCR1_MEM_CMD_RD)
          dmem.dmem_rdata <= rd_val;
      end
    end
  end

  assign wdt_irq     = irq_pend & en;
  assign wdt_rst_req = state == SCR1_WDT_BITE;

  logic unused_bits;
`ifdef SCR1_WDT_WINDOW_EN
  assign unused_bits = ^{dmem.dmem_addr[31:5],
    timer_val[63:32]};
`else
  assign unused_bits = ^{dmem.dmem_addr[31:5],
    timer_val[63:32], cnt};
`endif

endmodule
